// File: rtl/execute_muldiv_sequencer.sv
// rtl/execute_muldiv_sequencer.sv - iterative radix-2 unsigned mul/div unit for the execute stage
// Shift-add multiply and restoring divide, one step per cycle, with stall/flush handshake.
module execute_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Start,
  input  logic [1:0]      i_Op,
  input  logic [XLEN-1:0] i_SrcA,
  input  logic [XLEN-1:0] i_SrcB,
  input  logic            i_FlushE,
  output logic            o_StallReq,
  output logic            o_Busy,
  output logic            o_Done,
  output logic [XLEN-1:0] o_Result
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   result_q, result_d;

  // hi/lo hold {product_hi, product_lo} for multiply and {rem, quo} for divide
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [XLEN-1:0]   step_hi, step_lo;
  logic              stall;

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};

    rem_sh  = {hi_q, lo_q[XLEN-1]};
    div_ge  = (rem_sh >= {1'b0, opnd_q});
    // remainder after a successful trial is below the divisor, so XLEN bits suffice
    div_rem = div_ge ? (rem_sh[XLEN-1:0] - opnd_q) : rem_sh[XLEN-1:0];
    div_quo = {lo_q[XLEN-2:0], div_ge};

    step_hi = op_q[1] ? div_rem : mul_hi;
    step_lo = op_q[1] ? div_quo : mul_lo;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    stall    = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = i_Start & ~i_FlushE;
        if (stall) begin
          op_d  = i_Op;
          hi_d  = '0;
          cnt_d = CNT_W'(XLEN);
          if (i_Op[1]) begin
            opnd_d = i_SrcB;
            lo_d   = i_SrcA;
          end else begin
            opnd_d = i_SrcA;
            lo_d   = i_SrcB;
          end
          if (i_Op[1] && (i_SrcB == '0)) begin
            result_d = (i_Op == OP_DIVU) ? '1 : i_SrcA;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (i_FlushE) begin
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
          hi_d  = step_hi;
          lo_d  = step_lo;
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_DONE;
            case (op_q)
              OP_MUL:   result_d = step_lo;
              OP_MULHU: result_d = step_hi;
              OP_DIVU:  result_d = step_lo;
              default:  result_d = step_hi;
            endcase
          end
        end
      end

      S_DONE: begin
        // i_Start still belongs to the completing instruction here
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign o_StallReq = stall & ~i_Reset;
  assign o_Busy     = (state_q == S_RUN);
  assign o_Done     = (state_q == S_DONE);
  assign o_Result   = result_q;

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// tb/tb_execute_muldiv_sequencer.sv - directed scoreboard bench for execute_muldiv_sequencer
// Expected results are queued at issue time and popped when o_Done pulses.
module tb_execute_muldiv_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_Reset;
  logic        i_Start;
  logic [1:0]  i_Op;
  logic [31:0] i_SrcA;
  logic [31:0] i_SrcB;
  logic        i_FlushE;
  logic        o_StallReq;
  logic        o_Busy;
  logic        o_Done;
  logic [31:0] o_Result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_result = 32'h0;

  execute_muldiv_sequencer #(.XLEN(32)) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Start    (i_Start),
    .i_Op       (i_Op),
    .i_SrcA     (i_SrcA),
    .i_SrcB     (i_SrcB),
    .i_FlushE   (i_FlushE),
    .o_StallReq (o_StallReq),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Result   (o_Result)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'h0, a} * {32'h0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one op at the next negedge, wait for o_Done and score it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int          n;
    logic        got;
    logic        gap;
    logic [31:0] want;
    @(negedge i_Clk);
    i_Op = op; i_SrcA = a; i_SrcB = b; i_Start = 1'b1;
    sb.push_back(exp);
    #1;
    chk({tag, " stall_at_issue"}, {31'h0, o_StallReq}, 32'h1);
    n = 0; got = 1'b0; gap = 1'b0;
    while (!got && n < 100) begin
      @(negedge i_Clk);
      n++;
      if (o_Done) got = 1'b1;
      else if (!o_StallReq) gap = 1'b1;
    end
    chk({tag, " done_seen"}, {31'h0, got}, 32'h1);
    want = sb.pop_front();
    if (got) begin
      chk({tag, " latency"}, n, lat);
      chk({tag, " result"}, o_Result, want);
      chk({tag, " stall_in_done"}, {31'h0, o_StallReq}, 32'h0);
      chk({tag, " stall_continuous"}, {31'h0, gap}, 32'h0);
      last_result = want;
    end
    i_Start = 1'b0;
  endtask

  initial begin
    int          n;
    logic        seen;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;

    i_Reset = 1'b1; i_Start = 1'b1; i_Op = 2'b00; i_SrcA = 32'h0; i_SrcB = 32'h0; i_FlushE = 1'b0;
    #12;
    chk("rst done", {31'h0, o_Done}, 32'h0);
    chk("rst busy", {31'h0, o_Busy}, 32'h0);
    chk("rst stall", {31'h0, o_StallReq}, 32'h0);
    chk("rst result", o_Result, 32'h0);
    @(negedge i_Clk);
    i_Start = 1'b0;
    i_Reset = 1'b0;

    run_op("mul_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 33);
    @(negedge i_Clk);
    chk("result_held", o_Result, last_result);
    chk("done_one_cycle", {31'h0, o_Done}, 32'h0);

    run_op("mulhu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mul_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_by0", 2'b10, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
    run_op("remu_by0", 2'b11, 32'h1234, 32'h0, 32'h0000_1234, 1);
    run_op("divu_small_big", 2'b10, 32'd5, 32'hFFFF_FFF0, 32'd0, 33);
    run_op("remu_max_1", 2'b11, 32'hFFFF_FFFF, 32'd1, 32'd0, 33);

    for (int k = 0; k < 6; k++) begin
      op = 2'(k % 4);
      a  = $urandom;
      b  = $urandom_range(1, 32'hFFFF);
      run_op("rand", op, a, b, model(op, a, b), 33);
    end

    // flush during RUN
    @(negedge i_Clk);
    i_Op = 2'b00; i_SrcA = 32'd9; i_SrcB = 32'd9; i_Start = 1'b1;
    repeat (10) @(negedge i_Clk);
    i_FlushE = 1'b1;
    #1;
    chk("flush stall_drop", {31'h0, o_StallReq}, 32'h0);
    @(negedge i_Clk);
    chk("flush idle", {31'h0, o_Busy}, 32'h0);
    i_Start = 1'b0; i_FlushE = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge i_Clk);
      if (o_Done) seen = 1'b1;
    end
    chk("flush no_done", {31'h0, seen}, 32'h0);
    chk("flush result_kept", o_Result, last_result);

    // asynchronous reset mid-RUN
    @(negedge i_Clk);
    i_Op = 2'b00; i_SrcA = 32'h1234; i_SrcB = 32'h10; i_Start = 1'b1;
    repeat (20) @(negedge i_Clk);
    #2 i_Reset = 1'b1;
    #1;
    chk("midrst stall", {31'h0, o_StallReq}, 32'h0);
    chk("midrst busy", {31'h0, o_Busy}, 32'h0);
    chk("midrst done", {31'h0, o_Done}, 32'h0);
    chk("midrst result", o_Result, 32'h0);
    @(negedge i_Clk);
    i_Reset = 1'b0; i_Start = 1'b0;
    last_result = 32'h0;

    run_op("mul_3x5_after_rst", 2'b00, 32'd3, 32'd5, 32'd15, 33);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
